// File: rtl/pattern_source.sv
// pattern_source
//
// Upstream stimulus stage for a valid/ready stream consumer. A start pulse
// accepted in IDLE launches an arithmetic sequence of `length` beats:
// start_value, start_value+step, start_value+2*step, ... (modulo 2^DATA_WIDTH).
// An optional gap of idle cycles can be inserted between beats. Backpressure
// is honoured: a beat is held until the consumer accepts it.
//
// Ports
//   clk          sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        begin a sequence (only looked at while idle)
//   start_value  first beat value, latched on an accepted start
//   step         increment between beats, latched on start
//   length       number of beats (0 completes immediately), latched on start
//   gap          idle cycles between beats, latched on start
//   data         registered stream payload
//   valid        registered stream valid
//   ready        stream ready from the consumer
//   busy         high from an accepted start until the final handshake
//   done         one-cycle completion pulse
//   num_sent     beats handshaken in the current or last sequence

module pattern_source #(
    parameter int DATA_WIDTH    = 8,
    parameter int COUNTER_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [DATA_WIDTH-1:0]    start_value,
    input  logic [DATA_WIDTH-1:0]    step,
    input  logic [COUNTER_WIDTH-1:0] length,
    input  logic [COUNTER_WIDTH-1:0] gap,
    output logic [DATA_WIDTH-1:0]    data,
    output logic                     valid,
    input  logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic [COUNTER_WIDTH-1:0] num_sent
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t                   state, state_next;
    logic [DATA_WIDTH-1:0]    data_next;
    logic                     valid_next;
    logic                     busy_next;
    logic                     done_next;
    logic [COUNTER_WIDTH-1:0] num_sent_next;
    logic [DATA_WIDTH-1:0]    step_q, step_next;
    logic [COUNTER_WIDTH-1:0] length_q, length_next;
    logic [COUNTER_WIDTH-1:0] gap_q, gap_next;
    logic [COUNTER_WIDTH-1:0] gap_cnt, gap_cnt_next;

    logic [COUNTER_WIDTH-1:0] sent_plus_one;
    logic                     last_beat;

    assign sent_plus_one = num_sent + COUNTER_WIDTH'(1);
    assign last_beat     = (sent_plus_one == length_q);

    // Every output and all latched configuration live in this one register
    // bank, so nothing downstream sees a combinational path from ready/start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            data     <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            num_sent <= '0;
            step_q   <= '0;
            length_q <= '0;
            gap_q    <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_next;
            data     <= data_next;
            valid    <= valid_next;
            busy     <= busy_next;
            done     <= done_next;
            num_sent <= num_sent_next;
            step_q   <= step_next;
            length_q <= length_next;
            gap_q    <= gap_next;
            gap_cnt  <= gap_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        data_next     = data;
        valid_next    = valid;
        busy_next     = busy;
        done_next     = 1'b0;
        num_sent_next = num_sent;
        step_next     = step_q;
        length_next   = length_q;
        gap_next      = gap_q;
        gap_cnt_next  = gap_cnt;

        case (state)
            IDLE: begin
                if (start) begin
                    num_sent_next = '0;
                    if (length != '0) begin
                        step_next   = step;
                        length_next = length;
                        gap_next    = gap;
                        data_next   = start_value;
                        valid_next  = 1'b1;
                        busy_next   = 1'b1;
                        state_next  = SEND;
                    end else begin
                        // An empty sequence completes at once without a beat.
                        done_next = 1'b1;
                    end
                end
            end

            SEND: begin
                if (ready) begin
                    num_sent_next = sent_plus_one;
                    if (last_beat) begin
                        valid_next = 1'b0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        data_next = data + step_q;
                        if (gap_q != '0) begin
                            valid_next   = 1'b0;
                            gap_cnt_next = gap_q;
                            state_next   = GAP;
                        end
                    end
                end
            end

            GAP: begin
                // Raising valid when the counter reads 1 gives exactly
                // `gap` low cycles after the handshake that entered GAP.
                gap_cnt_next = gap_cnt - COUNTER_WIDTH'(1);
                if (gap_cnt == COUNTER_WIDTH'(1)) begin
                    valid_next = 1'b1;
                    state_next = SEND;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pattern_source.sv
// tb_pattern_source
//
// Directed bench for pattern_source. Inputs change 1 ns after a rising edge
// and outputs are sampled at that same point, so each observation shows the
// registered state produced by the edge just taken.

module tb_pattern_source;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] start_value;
    logic [7:0] step;
    logic [3:0] length;
    logic [3:0] gap;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       busy;
    logic       done;
    logic [3:0] num_sent;

    int checks = 0;
    int errors = 0;

    pattern_source #(
        .DATA_WIDTH(8),
        .COUNTER_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .start_value(start_value),
        .step(step),
        .length(length),
        .gap(gap),
        .data(data),
        .valid(valid),
        .ready(ready),
        .busy(busy),
        .done(done),
        .num_sent(num_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_beat(input string tag, input logic [7:0] exp_data, input logic [3:0] exp_num);
        check({tag, " valid"}, 32'(valid), 32'd1);
        check({tag, " data"}, 32'(data), 32'(exp_data));
        check({tag, " num_sent"}, 32'(num_sent), 32'(exp_num));
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " done"}, 32'(done), 32'd0);
    endtask

    task automatic check_done(input string tag, input logic [3:0] exp_num);
        check({tag, " valid"}, 32'(valid), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " num_sent"}, 32'(num_sent), 32'(exp_num));
    endtask

    task automatic load(input logic [7:0] sv, input logic [7:0] st, input logic [3:0] len, input logic [3:0] g);
        start       = 1'b1;
        start_value = sv;
        step        = st;
        length      = len;
        gap         = g;
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        start_value = 8'h00;
        step        = 8'h00;
        length      = 4'd0;
        gap         = 4'd0;
        ready       = 1'b1;

        // Reset state, with ready high which must have no effect.
        #12;
        check("reset valid", 32'(valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset data", 32'(data), 32'd0);
        check("reset num_sent", 32'(num_sent), 32'd0);
        reset_n = 1'b1;
        tick();
        check("idle valid", 32'(valid), 32'd0);

        // Basic back-to-back sequence 0x12, 0x34, 0x56.
        load(8'h12, 8'h22, 4'd3, 4'd0);
        tick();
        start = 1'b0;
        check_beat("basic b0", 8'h12, 4'd0);
        tick();
        check_beat("basic b1", 8'h34, 4'd1);
        tick();
        check_beat("basic b2", 8'h56, 4'd2);
        tick();
        check_done("basic end", 4'd3);
        tick();
        check("basic done low", 32'(done), 32'd0);
        check("basic num hold", 32'(num_sent), 32'd3);

        // Backpressure: 0x78 held for three valid cycles, then 0x79.
        ready = 1'b0;
        load(8'h78, 8'h01, 4'd2, 4'd0);
        tick();
        start = 1'b0;
        check_beat("bp hold0", 8'h78, 4'd0);
        tick();
        check_beat("bp hold1", 8'h78, 4'd0);
        tick();
        check_beat("bp hold2", 8'h78, 4'd0);
        ready = 1'b1;
        tick();
        check_beat("bp b1", 8'h79, 4'd1);
        tick();
        check_done("bp end", 4'd2);

        // Gap of 2: valid 1,0,0,1,0,0,1 then low with done.
        load(8'h05, 8'h03, 4'd3, 4'd2);
        tick();
        start = 1'b0;
        check_beat("gap b0", 8'h05, 4'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("gap1 valid", 32'(valid), 32'd0);
            check("gap1 busy", 32'(busy), 32'd1);
        end
        tick();
        check_beat("gap b1", 8'h08, 4'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("gap2 valid", 32'(valid), 32'd0);
            check("gap2 busy", 32'(busy), 32'd1);
        end
        tick();
        check_beat("gap b2", 8'h0B, 4'd2);
        tick();
        check_done("gap end", 4'd3);

        // Wrap: 0xF0 then 0x10.
        load(8'hF0, 8'h20, 4'd2, 4'd0);
        tick();
        start = 1'b0;
        check_beat("wrap b0", 8'hF0, 4'd0);
        tick();
        check_beat("wrap b1", 8'h10, 4'd1);
        tick();
        check_done("wrap end", 4'd2);

        // Zero length, started in the cycle done is high.
        load(8'h33, 8'h01, 4'd0, 4'd0);
        tick();
        start = 1'b0;
        check_done("zero", 4'd0);
        tick();
        check("zero done low", 32'(done), 32'd0);
        check("zero valid", 32'(valid), 32'd0);

        // Start while busy is ignored, including the new config.
        ready = 1'b0;
        load(8'h40, 8'h01, 4'd3, 4'd0);
        tick();
        check_beat("busy b0", 8'h40, 4'd0);
        load(8'hAA, 8'h10, 4'd1, 4'd3);
        ready = 1'b1;
        tick();
        check_beat("busy b1", 8'h41, 4'd1);
        start = 1'b0;
        tick();
        check_beat("busy b2", 8'h42, 4'd2);
        tick();
        check_done("busy end", 4'd3);

        // Restart straight out of done: valid next cycle.
        load(8'h60, 8'h02, 4'd1, 4'd0);
        tick();
        start = 1'b0;
        check_beat("restart b0", 8'h60, 4'd0);
        tick();
        check_done("restart end", 4'd1);

        // Reset mid-sequence clears outputs without a clock edge.
        load(8'h10, 8'h01, 4'd3, 4'd0);
        tick();
        start = 1'b0;
        check_beat("rst b0", 8'h10, 4'd0);
        tick();
        check_beat("rst b1", 8'h11, 4'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst valid", 32'(valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst data", 32'(data), 32'd0);
        check("rst num_sent", 32'(num_sent), 32'd0);
        #3;
        reset_n = 1'b1;
        tick();
        tick();
        check("post rst valid", 32'(valid), 32'd0);
        check("post rst busy", 32'(busy), 32'd0);
        check("post rst done", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_source.md
# pattern_source

Upstream stimulus stage for the `fake_sink` stream consumer. On a start pulse it emits a programmable arithmetic sequence of `length` beats over a valid/ready stream, with an optional idle gap between beats. It honours backpressure, so the sink's `stall` input exercises the full handshake. The block drives bring-up and loopback benches and can feed any `DATA_WIDTH`-wide valid/ready consumer in the pipeline.

## Interface

Parameters:
- `DATA_WIDTH`, 8, width of `data`, `start_value` and `step`.
- `COUNTER_WIDTH`, 4, width of `length`, `gap` and `num_sent`.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  begin a sequence; sampled only in IDLE.
- `start_value`  input  DATA_WIDTH  first beat value; latched on an accepted start.
- `step`  input  DATA_WIDTH  increment between beats; latched on start.
- `length`  input  COUNTER_WIDTH  beats to send (0 to 2^COUNTER_WIDTH-1); latched on start.
- `gap`  input  COUNTER_WIDTH  idle cycles between beats; latched on start.
- `data`  output  DATA_WIDTH  stream payload; registered.
- `valid`  output  1  stream valid; registered.
- `ready`  input  1  stream ready from the consumer.
- `busy`  output  1  high from an accepted start until the final handshake.
- `done`  output  1  single-cycle pulse on sequence completion.
- `num_sent`  output  COUNTER_WIDTH  beats handshaken in the current or last sequence.

## Operation

- Reset (asynchronous, any state) forces: state IDLE, `data`=0, `valid`=0, `busy`=0, `done`=0, `num_sent`=0, and clears all latched config.
- A handshake is a rising edge with `valid`=1 and `ready`=1.
- `done` defaults to 0 every cycle unless set below.
- IDLE (`valid`=0, `busy`=0):
  - `start`=1 and `length`≠0: latch `step`, `length` and `gap`; set `data`←`start_value`, `valid`←1, `busy`←1, `num_sent`←0; go to SEND.
  - `start`=1 and `length`=0: set `num_sent`←0 and `done`←1; stay in IDLE; `valid` stays 0.
- SEND (`valid`=1):
  - No handshake: hold `data` and `valid`. `valid` never drops and `data` never changes without a handshake.
  - Handshake, last beat (`num_sent`+1 = length): increment `num_sent`; set `valid`←0, `busy`←0, `done`←1; go to IDLE.
  - Handshake, not last, gap=0: increment `num_sent`; `data`←`data`+step; stay in SEND (back-to-back beats).
  - Handshake, not last, gap≠0: increment `num_sent`; `data`←`data`+step; `valid`←0; gap counter←gap; go to GAP.
- GAP (`valid`=0, `busy`=1):
  - Decrement the gap counter each cycle.
  - When the counter is 1, set `valid`←1 and go to SEND.
  - Result: exactly `gap` cycles with `valid` low between beats.
- `start` is ignored while `busy`=1. Changes on the config inputs after start do not affect the running sequence.
- Arithmetic:
  - `data` wraps modulo 2^DATA_WIDTH with no saturation.
  - `num_sent` never exceeds the latched length, so no overflow occurs.
- `num_sent` holds its final value in IDLE until the next accepted start.
- `ready` is ignored when `valid`=0. A `ready` that is high in IDLE or GAP has no effect.

## Timing

- All outputs are registered. No combinational path runs from `ready` or `start` to any output.
- Start latency: `start` sampled at edge N gives `valid`=1 with `data`=`start_value` during cycle N+1.
- Back-to-back throughput (gap=0, `ready` held high): one beat per cycle.
- With gap=g: a handshake at edge N gives `valid`=0 for cycles N+1 through N+g, then `valid`=1 at cycle N+g+1.
- Completion: the final handshake at edge N gives `done`=1, `valid`=0 and `busy`=0 during cycle N+1. `done`=0 in cycle N+2.
- Re-start: a new `start` is accepted at edge N+1 (the cycle `done` is high). That gives `valid`=1 in cycle N+2.
- Reset asserted mid-sequence: outputs clear immediately, with no clock required. After release, the block waits in IDLE for a fresh `start`.

## Test plan

- Basic sequence: start_value=0x12, step=0x22, length=3, gap=0, `ready`=1 → `data` 0x12, 0x34, 0x56 on three consecutive `valid` cycles; `done` pulses once; `num_sent`=3; the sink's `num_values`=3 and `last_value`=0x56.
- Backpressure: start_value=0x78, step=1, length=2, `ready`=0 for 2 cycles then 1 → `data`=0x78 held with `valid`=1 for 3 cycles; next beat is 0x79; `num_sent` does not advance while stalled.
- Gap: length=3, gap=2, `ready`=1 → `valid` pattern 1,0,0,1,0,0,1, then low; `busy` stays high throughout; `done` comes one cycle after the third beat.
- Wrap and zero length:
  - start_value=0xF0, step=0x20, length=2 → beats 0xF0, 0x10.
  - length=0 → `valid` never asserts; `done`=1 exactly one cycle after `start`; `num_sent`=0.
- Start while busy: a second `start` with start_value=0xAA during an active sequence is ignored; the original beat values continue unchanged.
- Reset mid-sequence: `reset_n`=0 after beat 1 of 3 → `valid`, `busy`, `data` and `num_sent` all go to 0 without a clock edge.
